// File: rtl/icache_refill.sv
// ---------------------------------------------------------------------------
// icache_refill
//   Instruction-cache line refill engine. On a tag-stage miss the line address
//   and victim way are captured, the line is requested from memory, BEATS
//   32-bit beats are collected into a line buffer and the line is then written
//   into the data array (with a tag refresh pulse) in a single FILL cycle.
//   A flush during the bus transfer lets the transfer drain but suppresses the
//   write; bus errors or a stalled bus (TIMEOUT cycles) end in an ERR pulse.
//
// Ports
//   clk_i, rst_i           clock (rising edge), asynchronous active-high reset
//   miss_i, addr_i, lru_i  miss request, fetch address, victim way
//   flush_i                abort the refill in progress
//   mem_req_o/mem_addr_o   line request, line-aligned address
//   mem_gnt_i              request accepted
//   mem_rvalid_i/_rdata_i  read beats; mem_err_i flags a bad beat
//   refresh_o              tag update pulse (FILL)
//   data_we_o              one-hot way write enable {way1, way0}
//   data_index_o           set index of the refilled line
//   data_wdata_o           assembled line
//   stallreq_o             pipeline stall
//   refill_err_o           one-cycle error pulse
//   perf_miss_cnt_o        accepted misses           (ICACHE_REFILL_PERF_EN)
//   perf_cycle_cnt_o       cycles spent outside IDLE (ICACHE_REFILL_PERF_EN)
//
// Build option: define ICACHE_REFILL_PERF_EN to add saturating perf counters.
// ---------------------------------------------------------------------------
module icache_refill #(
    parameter int BEATS   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  miss_i,
    input  logic [63:0]           addr_i,
    input  logic                  lru_i,
    input  logic                  flush_i,
    output logic                  mem_req_o,
    output logic [63:0]           mem_addr_o,
    input  logic                  mem_gnt_i,
    input  logic                  mem_rvalid_i,
    input  logic [31:0]           mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  refresh_o,
    output logic [1:0]            data_we_o,
    output logic [5:0]            data_index_o,
    output logic [32*BEATS-1:0]   data_wdata_o,
    output logic                  stallreq_o,
    output logic                  refill_err_o
`ifdef ICACHE_REFILL_PERF_EN
    ,
    output logic [31:0]           perf_miss_cnt_o,
    output logic [31:0]           perf_cycle_cnt_o
`endif
);

    localparam int BCW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_RECV,
        S_FILL,
        S_ERR
    } state_e;

    state_e                state_q, state_d;
    logic [60:0]           line_addr_q, line_addr_d;  // addr[63:3]
    logic                  lru_q, lru_d;
    logic [BCW-1:0]        beat_q, beat_d;
    logic [TCW-1:0]        tmo_q, tmo_d;
    logic                  abort_q, abort_d;
    logic [32*BEATS-1:0]   lbuf_q, lbuf_d;

    // Byte offset is irrelevant: refills are always whole lines.
    logic unused_offset;
    assign unused_offset = ^addr_i[2:0];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            line_addr_q <= '0;
            lru_q       <= 1'b0;
            beat_q      <= '0;
            tmo_q       <= '0;
            abort_q     <= 1'b0;
            lbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            line_addr_q <= line_addr_d;
            lru_q       <= lru_d;
            beat_q      <= beat_d;
            tmo_q       <= tmo_d;
            abort_q     <= abort_d;
            lbuf_q      <= lbuf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        lru_d       = lru_q;
        beat_d      = beat_q;
        tmo_d       = tmo_q;
        abort_d     = abort_q;
        lbuf_d      = lbuf_q;
        case (state_q)
            S_IDLE: begin
                tmo_d   = '0;
                beat_d  = '0;
                abort_d = 1'b0;
                if (miss_i && !flush_i) begin
                    line_addr_d = addr_i[63:3];
                    lru_d       = lru_i;
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (mem_gnt_i) begin
                    // Grant beats a simultaneous flush: the bus transfer is
                    // committed, so drain it and only suppress the write.
                    state_d = S_RECV;
                    tmo_d   = '0;
                    abort_d = flush_i;
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            S_RECV: begin
                if (flush_i) abort_d = 1'b1;
                if (mem_rvalid_i) begin
                    tmo_d = '0;
                    if (mem_err_i) begin
                        state_d = S_ERR;
                    end else begin
                        lbuf_d[{beat_q, 5'b00000} +: 32] = mem_rdata_i;
                        if (beat_q == BCW'(BEATS - 1)) begin
                            beat_d  = '0;
                            state_d = S_FILL;
                        end else begin
                            beat_d = beat_q + BCW'(1);
                        end
                    end
                end else if (tmo_q == TCW'(TIMEOUT - 1)) begin
                    state_d = S_ERR;
                end else begin
                    tmo_d = tmo_q + TCW'(1);
                end
            end
            S_FILL:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic fill_ok;
    assign fill_ok      = (state_q == S_FILL) && !abort_q;

    assign mem_req_o    = (state_q == S_REQ);
    assign mem_addr_o   = {line_addr_q, 3'b000};
    assign refresh_o    = fill_ok;
    assign data_we_o    = fill_ok ? (lru_q ? 2'b10 : 2'b01) : 2'b00;
    assign data_index_o = line_addr_q[5:0];
    assign data_wdata_o = lbuf_q;
    assign stallreq_o   = (state_q != S_IDLE) || miss_i;
    assign refill_err_o = (state_q == S_ERR);

`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0] perf_miss_q, perf_cycle_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_miss_q  <= '0;
            perf_cycle_q <= '0;
        end else begin
            if (state_q == S_IDLE && miss_i && !flush_i && perf_miss_q != '1)
                perf_miss_q <= perf_miss_q + 32'd1;
            if (state_q != S_IDLE && perf_cycle_q != '1)
                perf_cycle_q <= perf_cycle_q + 32'd1;
        end
    end

    assign perf_miss_cnt_o  = perf_miss_q;
    assign perf_cycle_cnt_o = perf_cycle_q;
`else
    // Performance counters are not built.
`endif

endmodule

// File: tb/tb_icache_refill.sv
module tb_icache_refill;
    localparam int BEATS   = 2;
    localparam int TIMEOUT = 255;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                miss = 1'b0, lru = 1'b0, flush = 1'b0;
    logic [63:0]         addr = '0;
    logic                gnt = 1'b0, rvalid = 1'b0, merr = 1'b0;
    logic [31:0]         rdata = '0;
    logic                mem_req, refresh, stallreq, refill_err;
    logic [63:0]         mem_addr;
    logic [1:0]          data_we;
    logic [5:0]          data_index;
    logic [32*BEATS-1:0] data_wdata;
`ifdef ICACHE_REFILL_PERF_EN
    logic [31:0]         perf_miss_cnt, perf_cycle_cnt;
`endif

    icache_refill #(.BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
        .clk_i(clk), .rst_i(rst), .miss_i(miss), .addr_i(addr), .lru_i(lru),
        .flush_i(flush), .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(rdata),
        .mem_err_i(merr), .refresh_o(refresh), .data_we_o(data_we),
        .data_index_o(data_index), .data_wdata_o(data_wdata),
        .stallreq_o(stallreq), .refill_err_o(refill_err)
`ifdef ICACHE_REFILL_PERF_EN
        , .perf_miss_cnt_o(perf_miss_cnt), .perf_cycle_cnt_o(perf_cycle_cnt)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          is_err;
        logic [1:0]  we;
        logic [5:0]  idx;
        logic [63:0] data;
        int          at;
    } exp_t;

    exp_t        sbq[$];
    logic [63:0] addrq[$];
    int          checks = 0;
    int          fails  = 0;
    exp_t        mon_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant, a write
    // or an error pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_req && gnt) begin
                if (addrq.size() == 0) chk("unexpected_grant", 64'd1, 64'd0);
                else chk("mem_addr", mem_addr, addrq.pop_front());
            end
            if (data_we != 2'b00 && !refresh) chk("we_without_refresh", 64'(data_we), 64'd0);
            if (refresh || refill_err) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_output", 64'({refresh, refill_err}), 64'd0);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("err_pulse", 64'(refill_err), 64'(mon_e.is_err));
                    chk("refresh", 64'(refresh), 64'(!mon_e.is_err));
                    chk("event_cycle", 64'(cyc), 64'(mon_e.at));
                    if (mon_e.is_err) begin
                        chk("mem_req_in_err", 64'(mem_req), 64'd0);
                        chk("we_in_err", 64'(data_we), 64'd0);
                    end else begin
                        chk("data_we", 64'(data_we), 64'(mon_e.we));
                        chk("data_index", 64'(data_index), 64'(mon_e.idx));
                        chk("data_wdata", 64'(data_wdata), mon_e.data);
                    end
                end
            end
        end
    end

    task automatic wait_idle(input string name);
        int n = 0;
        while (stallreq && n < 50) begin
            step();
            n++;
        end
        chk({name, "_idle"}, 64'(stallreq), 64'd0);
        chk({name, "_sb_empty"}, 64'(sbq.size()), 64'd0);
    endtask

    task automatic chk_quiet(input string name);
        chk({name, "_mem_req"}, 64'(mem_req), 64'd0);
        chk({name, "_refresh"}, 64'(refresh), 64'd0);
        chk({name, "_data_we"}, 64'(data_we), 64'd0);
        chk({name, "_refill_err"}, 64'(refill_err), 64'd0);
        chk({name, "_stallreq"}, 64'(stallreq), 64'd0);
    endtask

    // kind: 0 normal, 1 flush during a beat, 2 flush in REQ before grant,
    //       3 mem_err on a beat, 4 flush together with grant
    task automatic run_txn(input int kind, input logic [63:0] a, input logic l,
                           input int d, input bit directed);
        logic [31:0]         dat [BEATS];
        int                  gap [BEATS];
        logic [32*BEATS-1:0] line;
        int                  fb, eb, nb, t;
        exp_t                e;
        fb = directed ? 0 : int'($urandom_range(0, BEATS - 1));
        eb = directed ? BEATS - 1 : int'($urandom_range(0, BEATS - 1));
        line = '0;
        for (int k = 0; k < BEATS; k++) begin
            gap[k] = directed ? 0 : int'($urandom_range(0, 2));
            dat[k] = directed ? 32'(32'h1111_1111 * (k + 1)) : $urandom;
            line[k*32 +: 32] = dat[k];
        end
        nb = (kind == 3) ? eb + 1 : BEATS;
        // miss cycle + one REQ cycle per refused grant + grant cycle, then
        // each consumed beat costs its gap plus its own cycle.
        t = cyc + 2 + d;
        for (int k = 0; k < nb; k++) t += gap[k] + 1;
        if (kind == 0 || kind == 3) begin
            e.is_err = (kind == 3);
            e.we     = l ? 2'b10 : 2'b01;
            e.idx    = a[8:3];
            e.data   = 64'(line);
            e.at     = t;
            sbq.push_back(e);
        end
        if (kind != 2) addrq.push_back({a[63:3], 3'b000});

        miss = 1'b1; addr = a; lru = l;
        #1;
        chk("stall_on_miss", 64'(stallreq), 64'd1);
        step();
        miss = 1'b0; addr = {$urandom, $urandom}; lru = ~l;
        if (kind == 2) begin
            repeat (d) begin
                rvalid = 1'b1; merr = 1'b1; rdata = $urandom;
                step();
            end
            rvalid = 1'b0; merr = 1'b0;
            flush = 1'b1;
            step();
            flush = 1'b0;
            chk("flush_req_drop", 64'(mem_req), 64'd0);
            wait_idle("flush_req");
            return;
        end
        repeat (d) step();
        gnt = 1'b1; flush = (kind == 4);
        step();
        gnt = 1'b0; flush = 1'b0;
        for (int k = 0; k < nb; k++) begin
            repeat (gap[k]) step();
            rvalid = 1'b1; rdata = dat[k];
            merr   = (kind == 3 && k == eb);
            flush  = (kind == 1 && k == fb);
            step();
            rvalid = 1'b0; merr = 1'b0; flush = 1'b0;
        end
        wait_idle("txn");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   n;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_quiet("reset");
        rst = 1'b0;
        step();

`ifdef ICACHE_REFILL_PERF_EN
        for (int i = 0; i < 3; i++) run_txn(0, 64'h1000 + 64'(i * 8), 1'b0, 0, 1'b1);
        chk("perf_miss_cnt", 64'(perf_miss_cnt), 64'd3);
        chk("perf_cycle_cnt", 64'(perf_cycle_cnt), 64'd12);
`endif

        // Directed cases
        run_txn(0, 64'h0000_0000_8000_0048, 1'b1, 0, 1'b1);
        run_txn(1, 64'h0000_0000_8000_0048, 1'b1, 0, 1'b1);
        run_txn(3, 64'h0000_0000_8000_0048, 1'b1, 0, 1'b1);
        run_txn(2, 64'h0000_1234_5678_9ab8, 1'b0, 2, 1'b1);
        run_txn(4, 64'h0000_0000_0000_0ff8, 1'b1, 1, 1'b1);

        // Grant withheld: error after TIMEOUT refused cycles
        e.is_err = 1'b1; e.we = 2'b00; e.idx = '0; e.data = '0;
        e.at = cyc + TIMEOUT + 1;
        sbq.push_back(e);
        miss = 1'b1; addr = 64'h0000_0000_0000_4000; lru = 1'b0;
        step();
        miss = 1'b0;
        n = 0;
        while (stallreq && n < TIMEOUT + 10) begin
            step();
            n++;
        end
        chk("timeout_idle", 64'(stallreq), 64'd0);
        chk("timeout_sb_empty", 64'(sbq.size()), 64'd0);

        // Reset after beat 0
        addrq.push_back(64'h0000_0000_0000_2340);
        miss = 1'b1; addr = 64'h0000_0000_0000_2344; lru = 1'b1;
        step();
        miss = 1'b0;
        gnt = 1'b1;
        step();
        gnt = 1'b0; rvalid = 1'b1; rdata = 32'hdead_beef;
        step();
        rvalid = 1'b0;
        rst = 1'b1;
        #1;
        chk_quiet("mid_recv_reset");
        step();
        rst = 1'b0;
        // late beat arriving in IDLE must be ignored
        rvalid = 1'b1; merr = 1'b1; rdata = 32'h5555_aaaa;
        step();
        rvalid = 1'b0; merr = 1'b0;
        chk("post_reset_queue", 64'(addrq.size()), 64'd0);
        run_txn(0, 64'h0000_0000_0000_2340, 1'b0, 0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                rvalid = 1'b1; merr = 1'b1; rdata = $urandom;
                step();
                rvalid = 1'b0; merr = 1'b0;
            end
            run_txn(int'($urandom_range(0, 4)), {$urandom, $urandom}, 1'($urandom),
                    int'($urandom_range(0, 3)), 1'b0);
        end

        step();
        chk("final_addrq_empty", 64'(addrq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
ICACHE_REFILL -- requirements
Module: icache_refill

Interface
REQ-001 SHALL have parameter: BEATS, default 2, number of 32-bit bus beats per 64-bit cache line.
REQ-002 SHALL have parameter: TIMEOUT, default 255, maximum cycles waiting for mem_gnt or the next mem_rvalid before error.
REQ-003 SHALL have ports: clk  in  1  clock, rising edge; one clock domain.
REQ-004 SHALL have port: rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports: miss in 1 from tag stage; addr in 64 fetch address {tag[54:0], index[5:0], offset[2:0]}; lru in 1 victim way for index; flush in 1 abort current refill.
REQ-006 SHALL have ports: mem_req out 1; mem_addr out 64, line-aligned (offset zero); mem_gnt in 1; mem_rvalid in 1; mem_rdata in 32; mem_err in 1.
REQ-007 SHALL have ports: refresh out 1 tag-update pulse; data_we out 2 one-hot way write enable {way1, way0}; data_index out 6; data_wdata out 64; stallreq out 1; refill_err out 1 pulse.

Function
REQ-008 SHALL implement FSM IDLE -> REQ -> RECV -> FILL -> IDLE, plus ERR.
REQ-009 In IDLE with miss=1 and flush=0, SHALL latch addr[63:3], lru, and enter REQ next cycle; miss ignored in other states.
REQ-010 In REQ SHALL hold mem_req=1 with stable mem_addr={latched addr[63:3],3'b0} until mem_gnt=1; on grant go RECV, mem_req low next cycle.
REQ-011 In RECV each mem_rvalid beat SHALL shift into a line buffer, beat 0 into bits [31:0], beat k into [32k+31:32k]; beat counter wraps to 0 after BEATS beats and FSM enters FILL.
REQ-012 In FILL, for exactly one cycle: refresh=1, data_we[latched lru]=1, data_index=latched index, data_wdata=line buffer; then IDLE.
REQ-013 Refill latency with gnt in REQ cycle 1 and back-to-back rvalid SHALL be BEATS+2 cycles from miss to refresh.
REQ-014 stallreq SHALL equal 1 in REQ, RECV, FILL, ERR, and combinationally equal miss in IDLE.
REQ-015 flush in REQ before grant SHALL drop mem_req and return to IDLE next cycle.
REQ-016 flush in RECV SHALL set an abort flag; remaining beats are drained; FILL then asserts neither refresh nor data_we.
REQ-017 flush and mem_gnt in the same REQ cycle: grant wins, transfer proceeds as in REQ-016.
REQ-018 mem_err with mem_rvalid, or timeout counter reaching TIMEOUT in REQ/RECV, SHALL enter ERR: mem_req=0, refill_err=1 for one cycle, no refresh, then IDLE.
REQ-019 mem_rvalid outside RECV SHALL be ignored.

Reset
REQ-020 rst SHALL asynchronously force IDLE; mem_req, refresh, data_we, refill_err, stallreq(registered part), counters, abort flag, line buffer all 0.
REQ-021 rst mid-RECV SHALL discard partial line; no refresh after rst release.

Configuration
REQ-022 Macro ICACHE_REFILL_PERF_EN defined: SHALL add outputs perf_miss_cnt (32) counting accepted misses and perf_cycle_cnt (32) counting non-IDLE cycles, both saturating at all-ones, reset to 0.
REQ-023 Macro undefined: those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-024 miss=1, addr=0x8000_0048, lru=1, gnt immediate, rdata 0x1111_1111 then 0x2222_2222 -> mem_addr=0x8000_0048, refresh and data_we=2'b10 in cycle 4, data_index=9, data_wdata=0x2222_2222_1111_1111.
REQ-025 Same, flush during beat 0 -> both beats consumed, refresh=0, data_we=0, return IDLE.
REQ-026 mem_gnt held low 255 cycles -> refill_err pulse, mem_req=0, IDLE, no refresh.
REQ-027 rst asserted after beat 0 -> all outputs 0 immediately; next miss refills cleanly with lru=0 -> data_we=2'b01.
REQ-028 mem_err on beat 1 -> refill_err=1 one cycle, no tag/data write.
REQ-029 With ICACHE_REFILL_PERF_EN, three back-to-back refills at latency 4 -> perf_miss_cnt=3, perf_cycle_cnt=12.
